// File: rtl/crc_process.sv
// crc_process
//   Receive-path frame gate between the 10G MAC receiver and user logic.
//   Each received frame is buffered until the MAC delivers its CRC verdict.
//   Good frames are forwarded unchanged. Bad frames and frames refused at
//   admission are discarded silently. Neither side has backpressure.
//
// Optional feature macro: CRC_PROCESS_DROP_CNT_EN
//   When defined, adds o_drop_cnt, a saturating count of discarded frames.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-low reset
//   s_axis_r*               input frame stream (data, user, keep, last, valid)
//   i_crc_valid/i_crc_error verdict strobe for the oldest unresolved frame
//   m_axis_r*               output frame stream (registered, zero when idle)
//   o_drop_cnt              discarded-frame count (feature macro only)
//   o_dbg_state             read FSM state: 0 IDLE, 1 FWD, 2 SKIP
//
// Handshake: the input has no ready; every cycle with s_axis_rvalid=1 is a
// beat. The output has no ready; m_axis_rvalid=1 marks a beat that the sink
// must take in that cycle.
module crc_process #(
    parameter int P_FIFO_DEPTH      = 512,
    parameter int P_MAX_FRAME_WORDS = 192,
    parameter int P_FRAME_Q_DEPTH   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] s_axis_rdata,
    input  logic [79:0] s_axis_ruser,
    input  logic [7:0]  s_axis_rkeep,
    input  logic        s_axis_rlast,
    input  logic        s_axis_rvalid,
    input  logic        i_crc_valid,
    input  logic        i_crc_error,
    output logic [63:0] m_axis_rdata,
    output logic [79:0] m_axis_ruser,
    output logic [7:0]  m_axis_rkeep,
    output logic        m_axis_rlast,
    output logic        m_axis_rvalid,
`ifdef CRC_PROCESS_DROP_CNT_EN
    output logic [15:0] o_drop_cnt,
`endif
    output logic [1:0]  o_dbg_state
);
    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int QW = $clog2(P_FRAME_Q_DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
    localparam logic [QW:0] QPTR_ONE   = (QW+1)'(1);
    localparam logic [AW:0] USED_LIMIT = (AW+1)'(P_FIFO_DEPTH - P_MAX_FRAME_WORDS);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FWD = 2'd1, ST_SKIP = 2'd2} state_t;

    // Buffer word layout: {data[72:9], keep[8:1], last[0]}
    logic [72:0] buf_mem  [P_FIFO_DEPTH];
    logic        tag_mem  [P_FRAME_Q_DEPTH];  // 1 = accepted, 0 = dropped
    logic [79:0] user_mem [P_FRAME_Q_DEPTH];
    logic        vrd_mem  [P_FRAME_Q_DEPTH];  // 1 = bad CRC

    state_t      state_q, state_d;
    logic        sof_q, sof_d;
    logic        adm_q, adm_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QW:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [QW:0] user_wr_q, user_wr_d, user_rd_q, user_rd_d;
    logic [QW:0] vrd_wr_q, vrd_wr_d, vrd_rd_q, vrd_rd_d;
    logic [79:0] cur_user_q, cur_user_d;
    logic        pipe_vld_q, pipe_vld_d;
    logic [72:0] pipe_word_q, pipe_word_d;
    logic [63:0] m_data_q, m_data_d;
    logic [79:0] m_user_q, m_user_d;
    logic [7:0]  m_keep_q, m_keep_d;
    logic        m_last_q, m_last_d;
    logic        m_valid_q, m_valid_d;

    logic [AW:0] used;
    logic        tag_empty, tag_full, user_full, vrd_empty;
    logic        is_sof, admit_now, wr_en, tag_push, tag_pop, tag_write;
    logic        res_valid, res_tag, user_push, vrd_push, vrd_pop;
    logic [72:0] rd_word;

    always_comb begin
        used      = wr_ptr_q - rd_ptr_q;
        tag_empty = (tag_wr_q == tag_rd_q);
        tag_full  = (tag_wr_q[QW] != tag_rd_q[QW]) && (tag_wr_q[QW-1:0] == tag_rd_q[QW-1:0]);
        user_full = (user_wr_q[QW] != user_rd_q[QW]) && (user_wr_q[QW-1:0] == user_rd_q[QW-1:0]);
        vrd_empty = (vrd_wr_q == vrd_rd_q);

        // Write side: admission is decided at SOF and held for the frame.
        // The user queue is also checked so an admitted frame always has a
        // slot for its metadata.
        is_sof    = s_axis_rvalid && sof_q;
        admit_now = is_sof ? ((used <= USED_LIMIT) && !tag_full && !user_full) : adm_q;
        wr_en     = s_axis_rvalid && admit_now;
        user_push = is_sof && admit_now;
        tag_push  = s_axis_rvalid && s_axis_rlast;
        sof_d     = s_axis_rvalid ? s_axis_rlast : sof_q;
        adm_d     = is_sof ? admit_now : adm_q;
        wr_ptr_d  = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;

        // Verdict resolution. With an empty tag queue, a tag being pushed in
        // the same cycle is resolved directly instead of being queued.
        tag_pop   = 1'b0;
        res_valid = 1'b0;
        res_tag   = 1'b0;
        if (i_crc_valid) begin
            if (!tag_empty) begin
                tag_pop   = 1'b1;
                res_valid = 1'b1;
                res_tag   = tag_mem[tag_rd_q[QW-1:0]];
            end else if (tag_push) begin
                res_valid = 1'b1;
                res_tag   = admit_now;
            end
        end
        tag_write = tag_push && !(i_crc_valid && tag_empty) && (!tag_full || tag_pop);
        vrd_push  = res_valid && res_tag;
        tag_wr_d  = tag_write ? tag_wr_q + QPTR_ONE : tag_wr_q;
        tag_rd_d  = tag_pop ? tag_rd_q + QPTR_ONE : tag_rd_q;
        user_wr_d = user_push ? user_wr_q + QPTR_ONE : user_wr_q;
        vrd_wr_d  = vrd_push ? vrd_wr_q + QPTR_ONE : vrd_wr_q;

        // Read FSM. The buffer is read combinationally into a pipeline
        // register, then into the output registers, so the last flag of the
        // current word is known in the cycle it is read.
        rd_word     = buf_mem[rd_ptr_q[AW-1:0]];
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        vrd_pop     = 1'b0;
        cur_user_d  = cur_user_q;
        pipe_vld_d  = 1'b0;
        pipe_word_d = rd_word;
        case (state_q)
            ST_IDLE: begin
                if (!vrd_empty) begin
                    vrd_pop    = 1'b1;
                    cur_user_d = user_mem[user_rd_q[QW-1:0]];
                    state_d    = vrd_mem[vrd_rd_q[QW-1:0]] ? ST_SKIP : ST_FWD;
                end
            end
            ST_FWD: begin
                pipe_vld_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                if (rd_word[0]) state_d = ST_IDLE;
            end
            ST_SKIP: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (rd_word[0]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        vrd_rd_d  = vrd_pop ? vrd_rd_q + QPTR_ONE : vrd_rd_q;
        user_rd_d = vrd_pop ? user_rd_q + QPTR_ONE : user_rd_q;

        m_valid_d = pipe_vld_q;
        m_data_d  = pipe_vld_q ? pipe_word_q[72:9] : 64'd0;
        m_keep_d  = pipe_vld_q ? pipe_word_q[8:1] : 8'd0;
        m_last_d  = pipe_vld_q ? pipe_word_q[0] : 1'b0;
        m_user_d  = pipe_vld_q ? cur_user_q : 80'd0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            sof_q       <= 1'b1;
            adm_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            user_wr_q   <= '0;
            user_rd_q   <= '0;
            vrd_wr_q    <= '0;
            vrd_rd_q    <= '0;
            cur_user_q  <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_word_q <= '0;
            m_data_q    <= '0;
            m_user_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sof_q       <= sof_d;
            adm_q       <= adm_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            user_wr_q   <= user_wr_d;
            user_rd_q   <= user_rd_d;
            vrd_wr_q    <= vrd_wr_d;
            vrd_rd_q    <= vrd_rd_d;
            cur_user_q  <= cur_user_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_word_q <= pipe_word_d;
            m_data_q    <= m_data_d;
            m_user_q    <= m_user_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
        end
    end

    // Storage arrays carry no reset; pointers alone define their contents.
    always_ff @(posedge i_clk) begin
        if (wr_en)     buf_mem[wr_ptr_q[AW-1:0]]    <= {s_axis_rdata, s_axis_rkeep, s_axis_rlast};
        if (tag_write) tag_mem[tag_wr_q[QW-1:0]]    <= admit_now;
        if (user_push) user_mem[user_wr_q[QW-1:0]]  <= s_axis_ruser;
        if (vrd_push)  vrd_mem[vrd_wr_q[QW-1:0]]    <= i_crc_error;
    end

`ifdef CRC_PROCESS_DROP_CNT_EN
    // A frame is counted once, when its verdict is resolved: either it was
    // refused at admission or its CRC is bad.
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        drop_inc;

    always_comb begin
        drop_inc   = res_valid && (!res_tag || i_crc_error);
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

    assign m_axis_rdata  = m_data_q;
    assign m_axis_ruser  = m_user_q;
    assign m_axis_rkeep  = m_keep_q;
    assign m_axis_rlast  = m_last_q;
    assign m_axis_rvalid = m_valid_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_crc_process.sv
// tb_crc_process
//   Directed bench for crc_process. Inputs are driven on the falling edge,
//   outputs are sampled on the falling edge. Expected output beats are
//   queued as {user, data, keep, last} when a frame that must appear is sent.
module tb_crc_process;
    logic        clk;
    logic        i_rst;
    logic [63:0] s_axis_rdata;
    logic [79:0] s_axis_ruser;
    logic [7:0]  s_axis_rkeep;
    logic        s_axis_rlast;
    logic        s_axis_rvalid;
    logic        i_crc_valid;
    logic        i_crc_error;
    logic [63:0] m_axis_rdata;
    logic [79:0] m_axis_ruser;
    logic [7:0]  m_axis_rkeep;
    logic        m_axis_rlast;
    logic        m_axis_rvalid;
    logic [1:0]  o_dbg_state;
`ifdef CRC_PROCESS_DROP_CNT_EN
    logic [15:0] o_drop_cnt;
`endif

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [152:0] exp_q[$];
    logic         mon_prev_valid = 1'b0;
    logic         mon_prev_last  = 1'b0;

    crc_process dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .s_axis_rdata  (s_axis_rdata),
        .s_axis_ruser  (s_axis_ruser),
        .s_axis_rkeep  (s_axis_rkeep),
        .s_axis_rlast  (s_axis_rlast),
        .s_axis_rvalid (s_axis_rvalid),
        .i_crc_valid   (i_crc_valid),
        .i_crc_error   (i_crc_error),
        .m_axis_rdata  (m_axis_rdata),
        .m_axis_ruser  (m_axis_ruser),
        .m_axis_rkeep  (m_axis_rkeep),
        .m_axis_rlast  (m_axis_rlast),
        .m_axis_rvalid (m_axis_rvalid),
`ifdef CRC_PROCESS_DROP_CNT_EN
        .o_drop_cnt    (o_drop_cnt),
`endif
        .o_dbg_state   (o_dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks: drive() holds one cycle and then returns the bus to idle.
    task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l,
                         input logic [79:0] u, input logic v, input logic cv, input logic ce);
        s_axis_rdata  = d;
        s_axis_rkeep  = k;
        s_axis_rlast  = l;
        s_axis_ruser  = u;
        s_axis_rvalid = v;
        i_crc_valid   = cv;
        i_crc_error   = ce;
        @(negedge clk);
        s_axis_rvalid = 1'b0;
        i_crc_valid   = 1'b0;
        i_crc_error   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(64'd0, 8'd0, 1'b0, 80'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic crc_pulse(input logic err);
        drive(64'd0, 8'd0, 1'b0, 80'd0, 1'b0, 1'b1, err);
    endtask

    task automatic send_frame(input logic [63:0] base, input logic [63:0] step, input int nw,
                              input logic [7:0] klast, input logic [79:0] u, input logic expect_out,
                              input logic crc_at_last, input logic err);
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        for (int i = 0; i < nw; i++) begin
            d = base + step * 64'(i);
            l = (i == nw - 1);
            k = l ? klast : 8'hFF;
            if (expect_out) exp_q.push_back({u, d, k, l});
            drive(d, k, l, u, 1'b1, crc_at_last && l, err);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_rvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 160'(exp_q.size()), 160'(0));
    endtask

    // Scoreboard: every output beat must match the head of exp_q; beats of a
    // frame are contiguous, frames are separated by an idle cycle, and the
    // idle bus is all zero.
    always @(negedge clk) begin
        if (!i_rst) begin
            mon_prev_valid = 1'b0;
            mon_prev_last  = 1'b0;
        end else begin
            if (m_axis_rvalid) begin
                check("frame_gap", 160'(mon_prev_valid && mon_prev_last), 160'(1'b0));
                check("beat_expected", 160'(exp_q.size() != 0), 160'(1'b1));
                if (exp_q.size() != 0)
                    check("beat", 160'({m_axis_ruser, m_axis_rdata, m_axis_rkeep, m_axis_rlast}),
                          160'(exp_q.pop_front()));
            end else begin
                check("bubble", 160'(mon_prev_valid && !mon_prev_last), 160'(1'b0));
                check("idle_zero", 160'({m_axis_ruser, m_axis_rdata, m_axis_rkeep, m_axis_rlast}),
                      160'(0));
            end
            mon_prev_valid = m_axis_rvalid;
            mon_prev_last  = m_axis_rlast;
        end
    end

    logic [79:0] u0;
    logic [7:0]  ksweep [8];
    logic [5:0]  bad_pat;
    int          n_wait;

    initial begin
        u0      = {16'd10, 48'd0, 16'h0800};
        ksweep  = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        bad_pat = 6'b011010;  // frames 1..6: good, bad, good, bad, bad, good

        i_rst         = 1'b0;
        s_axis_rdata  = '0;
        s_axis_ruser  = '0;
        s_axis_rkeep  = '0;
        s_axis_rlast  = 1'b0;
        s_axis_rvalid = 1'b0;
        i_crc_valid   = 1'b0;
        i_crc_error   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 160'(m_axis_rvalid), 160'(1'b0));
        check("rst_data",  160'(m_axis_rdata),  160'(0));
        check("rst_user",  160'(m_axis_ruser),  160'(0));
        check("rst_keep",  160'(m_axis_rkeep),  160'(0));
        check("rst_last",  160'(m_axis_rlast),  160'(1'b0));
        check("rst_state", 160'(o_dbg_state),   160'(2'd0));
`ifdef CRC_PROCESS_DROP_CNT_EN
        check("rst_drop",  160'(o_drop_cnt),    160'(0));
`endif
        #2 i_rst = 1'b1;
        @(negedge clk);

        // Good frame, 10 beats of {8{n}}, with the 3-cycle verdict latency
        send_frame(64'd0, 64'h0101_0101_0101_0101, 10, 8'hFF, u0, 1'b1, 1'b0, 1'b0);
        crc_pulse(1'b0);
        check("lat_c1", 160'(m_axis_rvalid), 160'(1'b0));
        @(negedge clk);
        check("lat_c2", 160'(m_axis_rvalid), 160'(1'b0));
        @(negedge clk);
        check("lat_c3", 160'(m_axis_rvalid), 160'(1'b0));
        @(negedge clk);
        check("lat_c4", 160'(m_axis_rvalid), 160'(1'b1));
        wait_drain("good_drain");

        // Bad frame: nothing may appear
        send_frame(64'd0, 64'h0101_0101_0101_0101, 10, 8'hFF, u0, 1'b0, 1'b0, 1'b0);
        crc_pulse(1'b1);
        for (int i = 0; i < 15; i++) begin
            check("bad_no_out", 160'(m_axis_rvalid), 160'(1'b0));
            @(negedge clk);
        end
`ifdef CRC_PROCESS_DROP_CNT_EN
        check("drop_after_bad", 160'(o_drop_cnt), 160'(16'd1));
`endif

        // Six frames, verdicts good, bad, good, bad, bad, good
        for (int f = 0; f < 6; f++)
            send_frame({32'h0000_6000 + 32'(f), 32'd0}, 64'd1, 4, 8'hFF,
                       {16'd32, 48'h0000_1111_2222 + 48'(f), 16'h0800}, !bad_pat[f], 1'b0, 1'b0);
        for (int f = 0; f < 6; f++) crc_pulse(bad_pat[f]);
        wait_drain("six_drain");
`ifdef CRC_PROCESS_DROP_CNT_EN
        check("drop_after_six", 160'(o_drop_cnt), 160'(16'd4));
`endif

        // Last-beat rkeep sweep; verdict arrives with the last beat
        for (int i = 0; i < 8; i++)
            send_frame({32'h0000_7000 + 32'(i), 32'd0}, 64'd1, 3, ksweep[i],
                       {16'd24, 48'h0000_3333_4444 + 48'(i), 16'h86DD}, 1'b1, 1'b1, 1'b0);
        wait_drain("keep_drain");

        // Buffer pressure: A and B fill 350 words before any read, so C is
        // refused; its verdict is consumed and D (bad) / E (good) stay paired.
        send_frame(64'hAAAA_0000_0000_0000, 64'd1, 200, 8'hFF, {16'd1600, 48'hA, 16'h0800}, 1'b1, 1'b0, 1'b0);
        send_frame(64'hBBBB_0000_0000_0000, 64'd1, 150, 8'hF0, {16'd1196, 48'hB, 16'h0800}, 1'b1, 1'b1, 1'b0);
        send_frame(64'hCCCC_0000_0000_0000, 64'd1, 30,  8'hFF, {16'd240,  48'hC, 16'h0800}, 1'b0, 1'b0, 1'b0);
        crc_pulse(1'b0);
        crc_pulse(1'b0);
        idle(20);
        send_frame(64'hDDDD_0000_0000_0000, 64'd1, 5, 8'hFF, {16'd40, 48'hD, 16'h0800}, 1'b0, 1'b1, 1'b1);
        send_frame(64'hEEEE_0000_0000_0000, 64'd1, 5, 8'hC0, {16'd34, 48'hE, 16'h0800}, 1'b1, 1'b1, 1'b0);
        wait_drain("pressure_drain");
`ifdef CRC_PROCESS_DROP_CNT_EN
        check("drop_after_pressure", 160'(o_drop_cnt), 160'(16'd6));
`endif

        // Reset pulse mid-frame and mid-output
        send_frame(64'h1234_0000_0000_0000, 64'd1, 40, 8'hFF, {16'd320, 48'h1234, 16'h0800}, 1'b1, 1'b0, 1'b0);
        crc_pulse(1'b0);
        n_wait = 0;
        while (!m_axis_rvalid && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        check("mid_out_started", 160'(m_axis_rvalid), 160'(1'b1));
        for (int i = 0; i < 3; i++)
            drive(64'h5555_0000_0000_0000 + 64'(i), 8'hFF, 1'b0, 80'h5, 1'b1, 1'b0, 1'b0);
        #2 i_rst = 1'b0;
        #1;
        check("mid_rst_valid", 160'(m_axis_rvalid), 160'(1'b0));
        check("mid_rst_data",  160'(m_axis_rdata),  160'(0));
        check("mid_rst_user",  160'(m_axis_ruser),  160'(0));
        check("mid_rst_keep",  160'(m_axis_rkeep),  160'(0));
        check("mid_rst_last",  160'(m_axis_rlast),  160'(1'b0));
        check("mid_rst_state", 160'(o_dbg_state),   160'(2'd0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 i_rst = 1'b1;
        @(negedge clk);
`ifdef CRC_PROCESS_DROP_CNT_EN
        check("drop_after_rst", 160'(o_drop_cnt), 160'(0));
`endif
        send_frame(64'h9999_0000_0000_0000, 64'd1, 6, 8'hF8, {16'd45, 48'h9999, 16'h0800}, 1'b1, 1'b1, 1'b0);
        wait_drain("post_rst_drain");

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
